// File: rtl/aes256_key_sched_if.sv
// Key-load, status and round-key read bundle between the AES-256 key
// scheduler and the round datapath.
interface aes256_key_sched_if;
  localparam int unsigned KEYW = 256;
  localparam int unsigned RKW  = 128;

  logic            start;
  logic [KEYW-1:0] key;
  logic            busy;
  logic            done;
  logic            keys_valid;
  logic            rd_en;
  logic [3:0]      rd_idx;
  logic            rd_inv;
  logic            rd_valid;
  logic [RKW-1:0]  rk_out;

  modport master (
    output start, key, rd_en, rd_idx, rd_inv,
    input  busy, done, keys_valid, rd_valid, rk_out
  );

  modport slave (
    input  start, key, rd_en, rd_idx, rd_inv,
    output busy, done, keys_valid, rd_valid, rk_out
  );
endinterface

// File: rtl/aes256_key_sched.sv
// Iterative AES-256 key expansion: one 128-bit round key per cycle into a
// 15-entry register file, with a registered forward / equivalent-inverse read port.
module aes256_key_sched (
  input  logic               clk,
  input  logic               rst_n,
  aes256_key_sched_if.slave  kif
);
  localparam int unsigned NRK  = 15;
  localparam int unsigned KEYW = 256;
  localparam int unsigned RKW  = 128;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  state_t         state;
  logic [3:0]     cnt;
  logic           busy_q, done_q, keys_valid_q, rd_valid_q;
  logic [RKW-1:0] rk_out_q;
  logic [RKW-1:0] rk [NRK];

  logic [RKW-1:0] prev1_c, prev2_c, next_rk_c, rd_data_c;
  logic [31:0]    t_c, w0_c, w1_c, w2_c, w3_c;
  logic [7:0]     rcon_c;

  // Next round key from the two previously written round keys.
  always_comb begin
    prev1_c = rk[4'(cnt - 4'd1)];
    prev2_c = rk[4'(cnt - 4'd2)];
    rcon_c  = 8'(8'h01 << 3'(cnt[3:1] - 3'd1));
    if (!cnt[0]) t_c = sub_word({prev1_c[23:0], prev1_c[31:24]}) ^ {rcon_c, 24'h0};
    else         t_c = sub_word(prev1_c[31:0]);
    w0_c      = prev2_c[127:96] ^ t_c;
    w1_c      = prev2_c[95:64]  ^ w0_c;
    w2_c      = prev2_c[63:32]  ^ w1_c;
    w3_c      = prev2_c[31:0]   ^ w2_c;
    next_rk_c = {w0_c, w1_c, w2_c, w3_c};
  end

  // Read mux: reversed order and InvMixColumns on inner keys in inverse mode.
  always_comb begin
    rd_data_c = '0;
    if (kif.rd_idx <= 4'd14) begin
      if (!kif.rd_inv) begin
        rd_data_c = rk[kif.rd_idx];
      end else if (kif.rd_idx == 4'd0 || kif.rd_idx == 4'd14) begin
        rd_data_c = rk[4'(4'd14 - kif.rd_idx)];
      end else begin
        rd_data_c = rk[4'(4'd14 - kif.rd_idx)];
        rd_data_c = {inv_mix_col(rd_data_c[127:96]), inv_mix_col(rd_data_c[95:64]),
                     inv_mix_col(rd_data_c[63:32]),  inv_mix_col(rd_data_c[31:0])};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rk_out_q     <= '0;
      for (int i = 0; i < NRK; i++) rk[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (kif.start) begin
            rk[0]        <= kif.key[KEYW-1 -: RKW];
            rk[1]        <= kif.key[RKW-1:0];
            cnt          <= 4'd2;
            busy_q       <= 1'b1;
            keys_valid_q <= 1'b0;
            state        <= EXPAND;
          end
        end
        EXPAND: begin
          rk[cnt] <= next_rk_c;
          cnt     <= 4'(cnt + 4'd1);
          if (cnt == 4'd14) begin
            state        <= DONE;
            done_q       <= 1'b1;
            keys_valid_q <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      rd_valid_q <= kif.rd_en;
      if (kif.rd_en) rk_out_q <= rd_data_c;
    end
  end

  assign kif.busy       = busy_q;
  assign kif.done       = done_q;
  assign kif.keys_valid = keys_valid_q;
  assign kif.rd_valid   = rd_valid_q;
  assign kif.rk_out     = rk_out_q;
endmodule

// File: tb/tb_aes256_key_sched.sv
// Self-checking bench for aes256_key_sched against a table-driven FIPS-197
// key expansion model.
module tb_aes256_key_sched;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes256_key_sched_if kif();
  aes256_key_sched dut (.clk(clk), .rst_n(rst_n), .kif(kif.slave));

  int errors = 0;
  int checks = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] mrk [15];

  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KF = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table walking the field with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] m_sub(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [31:0] m_imc_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4], m11 [4], m13 [4], m14 [4];
    a[0] = c[31:24]; a[1] = c[23:16]; a[2] = c[15:8]; a[3] = c[7:0];
    for (int i = 0; i < 4; i++) begin
      logic [7:0] m2, m4, m8;
      m2 = xt(a[i]); m4 = xt(m2); m8 = xt(m4);
      m9[i] = m8 ^ a[i]; m11[i] = m8 ^ m2 ^ a[i]; m13[i] = m8 ^ m4 ^ a[i]; m14[i] = m8 ^ m4 ^ m2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3], m9[0] ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1] ^ m14[2] ^ m11[3], m11[0] ^ m13[1] ^ m9[2] ^ m14[3]};
  endfunction

  function automatic logic [127:0] m_imc(input logic [127:0] k);
    return {m_imc_col(k[127:96]), m_imc_col(k[95:64]), m_imc_col(k[63:32]), m_imc_col(k[31:0])};
  endfunction

  // Standard word-at-a-time FIPS-197 key expansion, Nk = 8.
  task automatic model_expand(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = m_sub({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = m_sub(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] exp_read(input int idx, input logic inv);
    if (idx > 14) return '0;
    if (!inv) return mrk[idx];
    if (idx == 0 || idx == 14) return mrk[14 - idx];
    return m_imc(mrk[14 - idx]);
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [255:0] k);
    kif.start = 1'b1; kif.key = k;
    tick();
    kif.start = 1'b0;
  endtask

  // Counts cycles from the start edge until done, with a bounded wait.
  task automatic wait_done(input int from, output int cyc, output int busy_cnt);
    cyc = from; busy_cnt = 0;
    while (!kif.done && cyc < 40) begin
      if (kif.busy) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic do_read(input int idx, input logic inv, output logic [127:0] data, output logic vld);
    kif.rd_en = 1'b1; kif.rd_idx = 4'(idx); kif.rd_inv = inv;
    tick();
    data = kif.rk_out; vld = kif.rd_valid;
    kif.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] d; logic v;
    checks++; if ({kif.busy, kif.done, kif.keys_valid, kif.rd_valid} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {kif.busy, kif.done, kif.keys_valid, kif.rd_valid}); end
    checks++; if (kif.rk_out !== 128'h0) begin errors++; $display("FAIL reset_rk_out: got %h expected 0", kif.rk_out); end
    do_read(5, 1'b1, d, v);
    checks++; if (d !== 128'h0 || v !== 1'b1) begin errors++; $display("FAIL reset_regfile: got %h/%b expected 0/1", d, v); end
  endtask

  task automatic test_expand_timing();
    int cyc, bc;
    do_start(K1);
    model_expand(K1);
    checks++; if (kif.busy !== 1'b1 || kif.keys_valid !== 1'b0) begin errors++; $display("FAIL start_flags: got busy=%b kv=%b expected 1/0", kif.busy, kif.keys_valid); end
    wait_done(0, cyc, bc);
    checks++; if (cyc != 13) begin errors++; $display("FAIL done_latency: got %0d expected 13", cyc); end
    checks++; if (bc != 13) begin errors++; $display("FAIL busy_cycles: got %0d expected 13", bc); end
    checks++; if (kif.keys_valid !== 1'b1 || kif.busy !== 1'b0) begin errors++; $display("FAIL done_flags: got kv=%b busy=%b expected 1/0", kif.keys_valid, kif.busy); end
    tick();
    checks++; if (kif.done !== 1'b0 || kif.keys_valid !== 1'b1) begin errors++; $display("FAIL done_pulse: got done=%b kv=%b expected 0/1", kif.done, kif.keys_valid); end
  endtask

  task automatic test_forward_reads();
    logic [127:0] d; logic v;
    logic [127:0] kat [4];
    int kidx [4];
    kat[0] = 128'h000102030405060708090a0b0c0d0e0f; kidx[0] = 0;
    kat[1] = 128'h101112131415161718191a1b1c1d1e1f; kidx[1] = 1;
    kat[2] = 128'ha573c29fa176c498a97fce93a572c09c; kidx[2] = 2;
    kat[3] = 128'h24fc79ccbf0979e9371ac23c6d68de36; kidx[3] = 14;
    for (int i = 0; i < 4; i++) begin
      do_read(kidx[i], 1'b0, d, v);
      checks++; if (d !== kat[i] || v !== 1'b1) begin errors++; $display("FAIL fwd_kat idx%0d: got %h/%b expected %h/1", kidx[i], d, v, kat[i]); end
    end
    for (int i = 0; i < 15; i++) begin
      do_read(i, 1'b0, d, v);
      checks++; if (d !== exp_read(i, 1'b0)) begin errors++; $display("FAIL fwd_model idx%0d: got %h expected %h", i, d, exp_read(i, 1'b0)); end
    end
  endtask

  task automatic test_inverse_reads();
    logic [127:0] d, last; logic v;
    do_read(0, 1'b1, d, v);
    checks++; if (d !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin errors++; $display("FAIL inv_idx0: got %h expected 24fc79ccbf0979e9371ac23c6d68de36", d); end
    do_read(14, 1'b1, d, v);
    checks++; if (d !== K1[255:128]) begin errors++; $display("FAIL inv_idx14: got %h expected %h", d, K1[255:128]); end
    do_read(1, 1'b1, d, v);
    checks++; if (d !== m_imc(128'h4e5a6699a9f24fe07e572baacdf8cdea)) begin errors++; $display("FAIL inv_idx1: got %h expected %h", d, m_imc(128'h4e5a6699a9f24fe07e572baacdf8cdea)); end
    for (int i = 0; i < 15; i++) begin
      do_read(i, 1'b1, d, v);
      checks++; if (d !== exp_read(i, 1'b1)) begin errors++; $display("FAIL inv_model idx%0d: got %h expected %h", i, d, exp_read(i, 1'b1)); end
    end
    last = exp_read(14, 1'b1);
    tick();
    checks++; if (kif.rd_valid !== 1'b0 || kif.rk_out !== last) begin errors++; $display("FAIL rd_hold: got %b/%h expected 0/%h", kif.rd_valid, kif.rk_out, last); end
  endtask

  task automatic test_start_ignored_and_rekey();
    int cyc, bc;
    logic [255:0] k2;
    logic [127:0] d; logic v;
    k2 = rand_key();
    do_start(k2);
    model_expand(k2);
    tick(); tick();
    kif.start = 1'b1; kif.key = rand_key();
    tick();
    kif.start = 1'b0;
    tick(); tick(); tick();
    kif.start = 1'b1; kif.key = rand_key();
    tick();
    kif.start = 1'b0;
    wait_done(7, cyc, bc);
    checks++; if (cyc != 13) begin errors++; $display("FAIL ignored_start_latency: got %0d expected 13", cyc); end
    do_read(0, 1'b0, d, v);
    checks++; if (d !== k2[255:128]) begin errors++; $display("FAIL ignored_start_rk0: got %h expected %h", d, k2[255:128]); end
    do_read(14, 1'b0, d, v);
    checks++; if (d !== mrk[14]) begin errors++; $display("FAIL ignored_start_rk14: got %h expected %h", d, mrk[14]); end
    do_start(KF);
    model_expand(KF);
    checks++; if (kif.keys_valid !== 1'b0 || kif.busy !== 1'b1) begin errors++; $display("FAIL rekey_flags: got kv=%b busy=%b expected 0/1", kif.keys_valid, kif.busy); end
    wait_done(0, cyc, bc);
    checks++; if (cyc != 13) begin errors++; $display("FAIL rekey_latency: got %0d expected 13", cyc); end
    do_read(14, 1'b0, d, v);
    checks++; if (d !== 128'hfe4890d1e6188d0b046df344706c631e) begin errors++; $display("FAIL fips_rk14: got %h expected fe4890d1e6188d0b046df344706c631e", d); end
  endtask

  task automatic test_random_keys();
    int cyc, bc;
    logic [255:0] k;
    logic [127:0] prev_rk0, d; logic v;
    for (int n = 0; n < 3; n++) begin
      prev_rk0 = mrk[0];
      k = rand_key();
      kif.start = 1'b1; kif.key = k;
      kif.rd_en = 1'b1; kif.rd_idx = 4'd0; kif.rd_inv = 1'b0;
      tick();
      kif.start = 1'b0; kif.rd_en = 1'b0;
      checks++; if (kif.rk_out !== prev_rk0) begin errors++; $display("FAIL read_with_start: got %h expected %h", kif.rk_out, prev_rk0); end
      model_expand(k);
      wait_done(0, cyc, bc);
      checks++; if (cyc != 13) begin errors++; $display("FAIL rand_latency: got %0d expected 13", cyc); end
      for (int i = 0; i < 15; i++) begin
        do_read(i, 1'b0, d, v);
        checks++; if (d !== exp_read(i, 1'b0)) begin errors++; $display("FAIL rand_fwd key%0d idx%0d: got %h expected %h", n, i, d, exp_read(i, 1'b0)); end
        do_read(i, 1'b1, d, v);
        checks++; if (d !== exp_read(i, 1'b1)) begin errors++; $display("FAIL rand_inv key%0d idx%0d: got %h expected %h", n, i, d, exp_read(i, 1'b1)); end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [127:0] d; logic v;
    do_start(rand_key());
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    checks++; if ({kif.busy, kif.keys_valid, kif.done} !== 3'b000) begin errors++; $display("FAIL abort_flags: got %b expected 000", {kif.busy, kif.keys_valid, kif.done}); end
    rst_n = 1'b1;
    do_read(0, 1'b0, d, v);
    checks++; if (d !== 128'h0 || v !== 1'b1) begin errors++; $display("FAIL abort_rk0: got %h/%b expected 0/1", d, v); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    logic [255:0] k;
    logic inv;
    k = rand_key();
    do_start(k);
    model_expand(k);
    wait_done(0, cyc, bc);
    checks++; if (cyc != 13) begin errors++; $display("FAIL b2b_latency: got %0d expected 13", cyc); end
    for (int i = 0; i < 16; i++) begin
      inv = 1'($urandom_range(0, 1));
      kif.rd_en = 1'b1; kif.rd_idx = 4'(i); kif.rd_inv = inv;
      tick();
      checks++; if (kif.rd_valid !== 1'b1 || kif.rk_out !== exp_read(i, inv)) begin errors++; $display("FAIL b2b idx%0d inv%0b: got %b/%h expected 1/%h", i, inv, kif.rd_valid, kif.rk_out, exp_read(i, inv)); end
    end
    kif.rd_en = 1'b0;
    tick();
    checks++; if (kif.rd_valid !== 1'b0 || kif.rk_out !== 128'h0) begin errors++; $display("FAIL b2b_idle: got %b/%h expected 0/0", kif.rd_valid, kif.rk_out); end
  endtask

  initial begin
    kif.start = 1'b0; kif.key = '0; kif.rd_en = 1'b0; kif.rd_idx = '0; kif.rd_inv = 1'b0;
    rst_n = 1'b0;
    build_sbox();
    tick(); tick();
    rst_n = 1'b1;
    test_reset();
    test_expand_timing();
    test_forward_reads();
    test_inverse_reads();
    test_start_ignored_and_rekey();
    test_random_keys();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
